spi_receiver: RTL and testbench

SPI slave-side receiver/transmitter for the other end of the `spi_generator` link. It samples `MOSI` and drives `MISO` on externally supplied `SCK`/`CS`, in all four CKP/CPH modes, MSB first. Each received byte is presented on `data_out` with a one-cycle `rx_valid` strobe. It sits between the SPI pins and the local datapath, all logic in the `CLK` domain.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_edge_sync.sv | 36 +++
 rtl/spi_receiver.sv | 131 +++++++++++++
 tb/tb_spi_receiver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: FSM state encoding,
// default frame width and the CPH sample-edge helper.
package spi_pkg;

  localparam int DATA_W_DFLT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  // CPH=0 samples on the leading SCK edge, CPH=1 on the trailing edge.
  function automatic logic sample_on_lead(input logic cph);
    return ~cph;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Per-pin front end: optional 2-flop synchronizer (SPI_RX_SYNC_EN) followed by
// a previous-level register and rise/fall detection.
module spi_edge_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

`ifdef SPI_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RESET) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], din};
  end

  assign level = sync_q[1];
`else
  assign level = din;
`endif

  // prev resets low so a CS already low at reset release never looks like a fall
  always_ff @(posedge CLK) begin
    if (RESET) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/spi_receiver.sv
// SPI slave receiver/transmitter, all four CKP/CPH modes, MSB first.
// Input synchronization is selected by SPI_RX_SYNC_EN inside spi_edge_sync.
//
//   state | meaning
//   IDLE  | CS high or waiting for a CS falling edge; MISO held at 0
//   SHIFT | frame active; sampling MOSI and shifting MISO on SCK edges
module spi_receiver
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              SCK,
  input  logic              CS,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] data_in,
  output logic              MISO,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W);

  spi_state_t        state, state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr, rx_next;

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_lvl;
  logic sck_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;
  logic lead_edge, trail_edge, sample_edge, shift_edge, last_bit;

  spi_edge_sync u_sync_sck (
    .CLK(CLK), .RESET(RESET), .din(SCK),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_edge_sync u_sync_cs (
    .CLK(CLK), .RESET(RESET), .din(CS),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync u_sync_mosi (
    .CLK(CLK), .RESET(RESET), .din(MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign lead_edge   = CKP ? sck_fall : sck_rise;
  assign trail_edge  = CKP ? sck_rise : sck_fall;
  assign sample_edge = sample_on_lead(CPH) ? lead_edge  : trail_edge;
  assign shift_edge  = sample_on_lead(CPH) ? trail_edge : lead_edge;
  assign last_bit    = (bit_cnt == CNT_W'(DATA_W - 1));
  assign rx_next     = {rx_sr[DATA_W-2:0], mosi_lvl};

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE:    if (cs_fall) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cs_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      MISO      <= 1'b0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        MISO <= 1'b0;
        if (cs_fall) begin
          tx_sr   <= data_in;
          rx_sr   <= '0;
          bit_cnt <= '0;
          MISO    <= data_in[DATA_W-1];
        end
      end else if (cs_rise) begin
        // a final sample landing with CS rise still completes the byte
        MISO    <= 1'b0;
        bit_cnt <= '0;
        if (sample_edge && last_bit) begin
          data_out <= rx_next;
          rx_valid <= 1'b1;
        end else if (bit_cnt != '0) begin
          frame_err <= 1'b1;
        end
      end else if (sample_edge) begin
        rx_sr <= rx_next;
        if (last_bit) begin
          bit_cnt  <= '0;
          data_out <= rx_next;
          rx_valid <= 1'b1;
          tx_sr    <= data_in;
          if (!CPH) MISO <= data_in[DATA_W-1];
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (shift_edge) begin
        if (CPH) begin
          MISO  <= tx_sr[DATA_W-1];
          tx_sr <= tx_sr << 1;
        end else if (bit_cnt != '0) begin
          // CPH=0: the shift edge right after a byte boundary keeps the preloaded MSB
          MISO  <= tx_sr[DATA_W-2];
          tx_sr <= tx_sr << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver: CLK-synchronous SPI master model,
// scoreboard of expected received bytes checked on every rx_valid pulse.
module tb_spi_receiver;

`ifdef SPI_RX_SYNC_EN
  localparam int HALF = 4;
`else
  localparam int HALF = 2;
`endif

  logic       CLK = 1'b0;
  logic       RESET, CKP, CPH, SCK, CS, MOSI;
  logic [7:0] data_in;
  logic       MISO, rx_valid, busy, frame_err;
  logic [7:0] data_out;

  int         n_cmp = 0;
  int         n_err = 0;
  int         rx_cnt = 0;
  int         ferr_cnt = 0;
  int         half = HALF;
  logic [7:0] sb[$];
  logic [7:0] rx;

  spi_receiver #(.DATA_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
    .MOSI(MOSI), .data_in(data_in), .MISO(MISO), .data_out(data_out),
    .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Scoreboard and pulse counters
  always @(negedge CLK) begin
    if (rx_valid) begin
      rx_cnt++;
      if (sb.size() == 0) check_val("rx_unexpected", 32'(rx_valid), 32'd0);
      else                check_val("rx_data", 32'(data_out), 32'(sb.pop_front()));
    end
    if (frame_err) ferr_cnt++;
  end

  task automatic cs_start(input logic [7:0] din);
    data_in = din;
    CS = 1'b0;
    wait_clk(half);
    check_val("busy_shift", 32'(busy), 32'd1);
  endtask

  task automatic cs_end();
    wait_clk(half);
    CS = 1'b1;
    wait_clk(half + 2);
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("miso_idle", 32'(MISO), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!CPH) begin
        MOSI = tx[i];
        wait_clk(half);
        rxb[i] = MISO;
        SCK = ~CKP;
        wait_clk(half);
        SCK = CKP;
      end else begin
        SCK = ~CKP;
        MOSI = tx[i];
        wait_clk(half);
        rxb[i] = MISO;
        SCK = CKP;
        wait_clk(half);
      end
    end
  endtask

  task automatic run_frame(input logic cpol, input logic cpha, input int h,
                           input logic [7:0] tx, input logic [7:0] din);
    logic [7:0] r;
    CKP = cpol; CPH = cpha; SCK = cpol; half = h;
    wait_clk(4);
    sb.push_back(tx);
    cs_start(din);
    xfer(tx, 8, r);
    cs_end();
    check_val($sformatf("miso_byte_m%0d", {cpol, cpha}), 32'(r), 32'(din));
  endtask

  initial begin
    RESET = 1'b1; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; CS = 1'b1;
    MOSI = 1'b0; data_in = 8'h00;
    wait_clk(4);
    RESET = 1'b0;
    wait_clk(2);
    check_val("rst_miso", 32'(MISO), 32'd0);
    check_val("rst_data_out", 32'(data_out), 32'd0);
    check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_frame_err", 32'(frame_err), 32'd0);

    // All four modes, then mode 0 at CLK/8
    run_frame(1'b0, 1'b0, HALF, 8'hA5, 8'h3C);
    run_frame(1'b0, 1'b1, HALF, 8'hC3, 8'h81);
    run_frame(1'b1, 1'b0, HALF, 8'hC3, 8'h81);
    run_frame(1'b1, 1'b1, HALF, 8'hC3, 8'h81);
    run_frame(1'b0, 1'b0, 4, 8'h5A, 8'hC6);
    check_val("rx_count_modes", 32'(rx_cnt), 32'd5);
    check_val("ferr_count_modes", 32'(ferr_cnt), 32'd0);

    // Back-to-back bytes, data_in changed after the first byte is latched
    CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; half = HALF;
    wait_clk(4);
    sb.push_back(8'h12);
    sb.push_back(8'h34);
    cs_start(8'hAA);
    data_in = 8'h55;
    xfer(8'h12, 8, rx);
    check_val("b2b_miso_0", 32'(rx), 32'hAA);
    xfer(8'h34, 8, rx);
    check_val("b2b_miso_1", 32'(rx), 32'h55);
    cs_end();
    check_val("rx_count_b2b", 32'(rx_cnt), 32'd7);

    // Abort after 5 bits
    cs_start(8'h00);
    xfer(8'hFF, 5, rx);
    cs_end();
    check_val("abort_ferr", 32'(ferr_cnt), 32'd1);
    check_val("abort_rx_count", 32'(rx_cnt), 32'd7);
    check_val("abort_data_hold", 32'(data_out), 32'h34);

    // Reset after 3 bits with CS low
    cs_start(8'h99);
    xfer(8'h0F, 3, rx);
    RESET = 1'b1;
    wait_clk(2);
    check_val("mrst_miso", 32'(MISO), 32'd0);
    check_val("mrst_data_out", 32'(data_out), 32'd0);
    check_val("mrst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_frame_err", 32'(frame_err), 32'd0);
    RESET = 1'b0;
    wait_clk(2);
    xfer(8'hFF, 8, rx);
    wait_clk(half);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    check_val("post_rst_miso", 32'(MISO), 32'd0);
    check_val("post_rst_rx_count", 32'(rx_cnt), 32'd7);
    CS = 1'b1;
    wait_clk(4);
    run_frame(1'b0, 1'b0, HALF, 8'hF0, 8'h0F);
    check_val("final_rx_count", 32'(rx_cnt), 32'd8);
    check_val("final_ferr_count", 32'(ferr_cnt), 32'd1);
    check_val("final_data_out", 32'(data_out), 32'hF0);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
